// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
//
// Purpose:
//    Grants one of NUM_REQ byte producers access to a single UART TX at a
//    time. It issues a one-cycle start with the winner's byte and holds the
//    grant until the frame completes. It then acknowledges the winner and
//    rotates priority. A frame watchdog traps a hung transmitter in a sticky
//    error state that only rst or soft_rst can clear.
//
// Ports:
//    clk       in   clock, all logic on the rising edge
//    rst       in   asynchronous active-low reset
//    soft_rst  in   synchronous active-high reset, same effect as rst
//    req       in   [NUM_REQ]   level request per requester, held until ack
//    req_data  in   [8*NUM_REQ] packed bytes, requester k at [8k+7:8k]
//    grant     out  [NUM_REQ]   one-hot owner, LAUNCH through DONE
//    ack       out  [NUM_REQ]   one-cycle pulse to the owner in DONE
//    tx_start  out  one-cycle start pulse to the UART TX
//    tx_data   out  [8] byte to the UART TX, stable LAUNCH through DONE
//    tx_busy   in   UART TX busy; blocks a new launch while high
//    tx_done   in   UART TX frame-complete pulse
//    timeout   out  sticky watchdog flag

module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 3,
   parameter int WDOG_CYCLES  = 12 * CLKS_PER_BIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 soft_rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic                 timeout
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_FRAME  = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   localparam logic [IW:0]    POS_ONE   = (IW+1)'(1);
   localparam logic [IW:0]    POS_N     = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]  LAST_INIT = IW'(NUM_REQ - 1);
   localparam logic [WW-1:0]  WDOG_ONE  = WW'(1);
   localparam logic [WW-1:0]  WDOG_LAST = WW'(WDOG_CYCLES - 1);

   logic [2:0]           state;
   logic [IW-1:0]        last;
   logic [IW-1:0]        owner;
   logic [WW-1:0]        wdog;

   logic [IW:0]          start_pos;
   logic [IW:0]          offset;
   logic [IW:0]          pos_sum;
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IW-1:0]        pick;
   logic [NUM_REQ-1:0]   pick_oh;
   logic [7:0]           pick_byte;

   // Rotate the request vector so that bit 0 is the requester right after
   // the last owner; the lowest set bit of the rotated vector then wins.
   // Doubling the vector turns the wrap-around into a plain right shift.
   assign start_pos = {1'b0, last} + POS_ONE;
   assign req_dbl   = {req, req};
   assign req_rot   = NUM_REQ'(req_dbl >> start_pos);

   always_comb begin
      offset = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = (IW+1)'(i);
         end
      end
      // start_pos + offset never exceeds 2*NUM_REQ-1, so one subtraction
      // is enough to bring it back into 0..NUM_REQ-1.
      pos_sum = start_pos + offset;
      if (pos_sum >= POS_N) begin
         pos_sum = pos_sum - POS_N;
      end
   end

   assign pick    = IW'(pos_sum);
   assign pick_oh = NUM_REQ'(1) << pick;

   always_comb begin
      pick_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == IW'(i)) begin
            pick_byte = req_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         last     <= LAST_INIT;
         owner    <= '0;
         wdog     <= '0;
         grant    <= '0;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         timeout  <= 1'b0;
      end else if (soft_rst) begin
         state    <= S_IDLE;
         last     <= LAST_INIT;
         owner    <= '0;
         wdog     <= '0;
         grant    <= '0;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         timeout  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         ack      <= '0;
         case (state)
            S_IDLE: begin
               if (|req && !tx_busy) begin
                  owner    <= pick;
                  tx_data  <= pick_byte;
                  grant    <= pick_oh;
                  tx_start <= 1'b1;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               // tx_done is deliberately not looked at here.
               wdog  <= '0;
               state <= S_FRAME;
            end
            S_FRAME: begin
               // tx_done wins over a watchdog expiry in the same cycle.
               if (tx_done) begin
                  ack   <= grant;
                  state <= S_DONE;
               end else if (wdog == WDOG_LAST) begin
                  grant   <= '0;
                  timeout <= 1'b1;
                  state   <= S_ERROR;
               end else begin
                  wdog <= wdog + WDOG_ONE;
               end
            end
            S_DONE: begin
               last  <= owner;
               grant <= '0;
               state <= S_IDLE;
            end
            S_ERROR: begin
               grant   <= '0;
               timeout <= 1'b1;
            end
            default: begin
               grant <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int WDOG = 36;

   logic          clk = 1'b0;
   logic          rst;
   logic          soft_rst;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  grant;
   logic [N-1:0]  ack;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic          tx_done;
   logic          timeout;

   int total = 0;
   int bad   = 0;
   int m_last;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .CLKS_PER_BIT (3),
      .WDOG_CYCLES  (WDOG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .soft_rst (soft_rst),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .timeout  (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference winner: scan from the requester after the last owner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int lst);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (lst + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int w);
      logic [N-1:0] one;
      one = 1;
      return one << w;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_start"}, tx_start, 0);
   endtask

   // Called at the falling edge of an IDLE cycle. Holds tx_busy for 'busy'
   // cycles, then expects a launch, pulses tx_done in cycle LAUNCH+d and
   // returns at the falling edge of the following IDLE cycle.
   task automatic do_frame(input logic [N-1:0] pat, input logic [31:0] data,
                           input int busy, input int d, input bit stray, input bit wiggle);
      int w;
      int gcnt;
      logic [7:0] b;
      req      = pat;
      req_data = data;
      tx_busy  = (busy > 0);
      for (int i = 0; i < busy; i++) begin
         @(negedge clk);
         chk("busy_start", tx_start, 0);
         chk("busy_grant", grant, 0);
         if (i == busy - 1) tx_busy = 1'b0;
      end
      w = rr_pick(pat, m_last);
      b = data[8*w +: 8];
      @(negedge clk);
      chk("launch_start", tx_start, 1);
      chk("launch_grant", grant, oh(w));
      chk("launch_data", tx_data, b);
      chk("launch_ack", ack, 0);
      gcnt = 0;
      for (int c = 0; c <= d; c++) begin
         if (c > 0) begin
            @(negedge clk);
            chk("frame_start", tx_start, 0);
            chk("frame_ack", ack, 0);
            chk("frame_data", tx_data, b);
            chk("frame_timeout", timeout, 0);
         end
         if (grant == oh(w)) gcnt++;
         if (wiggle) begin
            req_data = $urandom;
            req      = 4'($urandom);
         end
         tx_done = (c == d) || (stray && c == 0 && d >= 2);
      end
      @(negedge clk);
      tx_done = 1'b0;
      chk("done_ack", ack, oh(w));
      chk("done_start", tx_start, 0);
      chk("done_data", tx_data, b);
      if (grant == oh(w)) gcnt++;
      m_last = w;
      @(negedge clk);
      chk_quiet("idle");
      chk("grant_len", gcnt, d + 2);
   endtask

   initial begin
      int w;
      logic [7:0] b;
      logic [N-1:0] pat;

      rst      = 1'b0;
      soft_rst = 1'b0;
      req      = 4'hF;
      req_data = 32'h1234_5678;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      m_last   = N - 1;

      // Reset dominance
      repeat (20) begin
         @(negedge clk);
         chk_quiet("rst");
         chk("rst_timeout", timeout, 0);
         chk("rst_data", tx_data, 0);
      end
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      chk_quiet("post_rst");

      // Single request, tx_done 30 cycles after start
      do_frame(4'b0100, 32'h00A5_0000, 0, 30, 0, 0);

      // Fairness: eight frames with all requesting, then one more and 1001
      for (int i = 0; i < 9; i++) do_frame(4'hF, $urandom, 0, $urandom_range(1, 6), 0, 0);
      do_frame(4'b1001, $urandom, 0, 3, 0, 0);

      // Busy gating
      do_frame(4'b0010, $urandom, 10, 5, 0, 0);

      // Randomized frames
      repeat (40) begin
         do_frame(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3),
                  $urandom_range(1, 20), 1'($urandom), 1'($urandom));
      end

      // Watchdog
      pat      = 4'($urandom_range(1, 15));
      req      = pat;
      req_data = $urandom;
      w        = rr_pick(pat, m_last);
      b        = req_data[8*w +: 8];
      @(negedge clk);
      chk("wd_start", tx_start, 1);
      chk("wd_data", tx_data, b);
      for (int c = 1; c <= WDOG; c++) begin
         @(negedge clk);
         chk("wd_pre_timeout", timeout, 0);
         chk("wd_pre_grant", grant, oh(w));
      end
      @(negedge clk);
      chk("wd_timeout", timeout, 1);
      chk("wd_grant", grant, 0);
      repeat (50) begin
         req     = 4'($urandom);
         tx_busy = 1'($urandom);
         @(negedge clk);
         chk_quiet("err");
         chk("err_timeout", timeout, 1);
      end
      soft_rst = 1'b1;
      tx_busy  = 1'b0;
      req      = 4'hF;
      @(negedge clk);
      soft_rst = 1'b0;
      chk("srst_timeout", timeout, 0);
      chk_quiet("srst");
      m_last = N - 1;
      do_frame(4'hF, $urandom, 0, 4, 0, 0);

      // Reset mid-frame
      pat      = 4'($urandom_range(1, 15));
      req      = pat;
      req_data = $urandom;
      w        = rr_pick(pat, m_last);
      @(negedge clk);
      chk("mid_start", tx_start, 1);
      chk("mid_grant", grant, oh(w));
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_quiet("mid_async");
      chk("mid_async_data", tx_data, 0);
      chk("mid_async_timeout", timeout, 0);
      repeat (3) begin
         @(negedge clk);
         chk_quiet("mid_hold");
      end
      rst    = 1'b1;
      req    = '0;
      m_last = N - 1;
      @(negedge clk);
      chk_quiet("mid_release");
      do_frame(4'hF, $urandom, 0, 2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte producers. Each requester raises a request with its byte. The arbiter grants one requester at a time, issues a single-cycle start to the UART TX, and holds the grant until the frame completes. It then acknowledges the winner and rotates priority. A frame watchdog traps a hung transmitter in a sticky error state that only a reset or soft reset clears.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, default 3: UART bit period in clocks; must match the UART TX.
- `WDOG_CYCLES`, default `12*CLKS_PER_BIT`: maximum cycles in FRAME without `tx_done` before timeout.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `soft_rst` in 1: synchronous, active-high; same effect as `rst` on the next edge.
- `req` in `NUM_REQ`: request per requester; level, held until `ack`.
- `req_data` in `8*NUM_REQ`: packed bytes; requester k occupies bits `[8k+7:8k]`.
- `grant` out `NUM_REQ`: one-hot, high for the owner from LAUNCH through DONE inclusive.
- `ack` out `NUM_REQ`: one-cycle pulse to the owner in the DONE state.
- `tx_start` out 1: one-cycle pulse to the UART TX.
- `tx_data` out 8: byte to the UART TX, stable from LAUNCH through DONE.
- `tx_busy` in 1: UART TX busy.
- `tx_done` in 1: UART TX frame-complete pulse.
- `timeout` out 1: sticky watchdog flag.

## Operation
States are IDLE, LAUNCH, FRAME, DONE and ERROR.
- **IDLE**
  - If `|req` and `!tx_busy`: select the winner, latch `req_data[winner]` into `tx_data`, go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH**
  - `tx_start=1`, `grant[winner]=1`.
  - Go to FRAME unconditionally. `tx_done` is ignored in this state.
- **FRAME**
  - Watchdog counter starts at 0 on entry and increments every FRAME cycle.
  - If `tx_done` is sampled high: go to DONE.
  - Else if counter reaches `WDOG_CYCLES-1`: go to ERROR.
  - If `tx_done` and the watchdog limit occur in the same cycle, `tx_done` wins.
- **DONE**
  - `ack[winner]=1` for one cycle.
  - Pointer `last` becomes the winner.
  - Go to IDLE; `grant` drops on entry to IDLE.
- **ERROR**
  - `timeout=1` and `grant=0`.
  - All `req` are ignored and `tx_start` is never asserted.
  - Exit only via `rst` or `soft_rst`.

Winner selection:
- Scan starts at `(last+1) mod NUM_REQ` and wraps around.
- The first asserted `req` wins.

Other behaviour:
- Dropping `req` mid-frame does not abort the frame; `ack` is still pulsed.
- A requester with another byte may keep `req` high after `ack`. It re-competes at lowest priority behind the others.
- `req_data` changes after LAUNCH have no effect on the frame in progress.

Reset and soft-reset values:
- State IDLE, `last=NUM_REQ-1` (requester 0 has highest priority), watchdog 0.
- `grant=0`, `ack=0`, `tx_start=0`, `tx_data=8'h00`, `timeout=0`.
- `soft_rst` dominates every state transition. `rst` dominates `soft_rst`.

## Timing
- Request to start: `req` sampled in IDLE at edge N gives `tx_start` and `grant` high in cycle N+1. Latency is 1 cycle.
- Completion: `tx_done` sampled at edge M gives `ack` in cycle M+1 and IDLE in cycle M+2.
- Back-to-back: next `tx_start` no earlier than cycle M+3 (one IDLE cycle minimum between frames).
- `rst` assertion mid-frame: all outputs clear immediately (asynchronous), with no `ack` for the aborted frame.
- `grant` and `ack` are registered, glitch-free, and at most one-hot.

## Test plan
- **Reset dominance:** `rst=0` for 20 cycles with `req=4'b1111` → `grant`, `ack`, `tx_start`, `timeout` all 0 every cycle.
- **Single request:** `req[2]=1`, byte `8'hA5`, UART model pulses `tx_done` 30 cycles after start → one `tx_start` with `tx_data=8'hA5`, `grant=4'b0100` for 32 cycles, single `ack=4'b0100` pulse.
- **Fairness:** `req=4'b1111` held for 8 frames → grant order 0,1,2,3,0,1,2,3, each with correct `tx_data`. Then `req=4'b1001` after owner 0 → next grant 3.
- **Busy gating:** `tx_busy=1` in IDLE with `req[1]=1` for 10 cycles → no `tx_start`; `tx_start` asserts 1 cycle after `tx_busy` falls.
- **Watchdog:** `tx_done` never pulsed → `timeout=1` exactly `WDOG_CYCLES`=36 cycles after entering FRAME, `grant=0`, and further `req` ignored for 50 cycles. `soft_rst` pulse → `timeout=0`, and the next grant goes to requester 0.
- **Reset mid-frame:** `rst=0` 10 cycles into FRAME → outputs 0 immediately, no `ack`. After release, arbitration restarts with requester 0 first.
